// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing the EX-stage ALU between the issue port (0) and branch/aux port (1).
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always wins contention and no pointer is kept.
//
// state   | meaning
// S_EMPTY | no result held, rsp_valid = 0
// S_FULL  | one result held, rsp_valid = 1
module alu_share_arb #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_c,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_c,
   output logic             rsp_zero,
   output logic             rsp_err
);

   typedef enum logic {S_EMPTY = 1'b0, S_FULL = 1'b1} state_t;

   state_t           state_q, state_d;
   logic             grant0, grant1;
   logic             can_issue, accept, op_legal;
   logic [WIDTH-1:0] rsp_c_q, rsp_c_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_id_q, rsp_id_d;
   logic             rsp_err_q, rsp_err_d;

   // Grants look only at the valids so ready never feeds back into itself.
`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant0 = req0_valid;
      grant1 = req1_valid & ~req0_valid;
   end
`else
   logic ptr_q, ptr_d;

   always_comb begin
      grant0 = req0_valid & (~req1_valid | ~ptr_q);
      grant1 = req1_valid & (~req0_valid | ptr_q);
      ptr_d  = accept ? ~ptr_q : ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   assign can_issue  = (state_q == S_EMPTY) | rsp_ready;
   assign accept     = can_issue & (grant0 | grant1);
   assign req0_ready = rst_n & can_issue & grant0;
   assign req1_ready = rst_n & can_issue & grant1;

   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = 4'b0000;
      if (grant0) begin
         alu_a    = req0_a;
         alu_b    = req0_b;
         alu_ctrl = req0_op;
      end else if (grant1) begin
         alu_a    = req1_a;
         alu_b    = req1_b;
         alu_ctrl = req1_op;
      end
   end

   always_comb begin
      case (alu_ctrl)
         4'b0000, 4'b0001, 4'b0010, 4'b0011,
         4'b0100, 4'b0101, 4'b0110, 4'b0111,
         4'b1000, 4'b1001, 4'b1010, 4'b1100: op_legal = 1'b1;
         default:                             op_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_EMPTY: if (accept) state_d = S_FULL;
         S_FULL:  if (!accept && rsp_ready) state_d = S_EMPTY;
         default: state_d = S_EMPTY;
      endcase
   end

   always_comb begin
      rsp_valid = (state_q == S_FULL);
   end

   // The ALU keeps its previous C on unknown codes, so illegal ops report zeros instead.
   always_comb begin
      rsp_c_d    = rsp_c_q;
      rsp_zero_d = rsp_zero_q;
      rsp_id_d   = rsp_id_q;
      rsp_err_d  = rsp_err_q;
      if (accept) begin
         rsp_id_d = grant1;
         if (op_legal) begin
            rsp_c_d    = alu_c;
            rsp_zero_d = alu_zero;
            rsp_err_d  = 1'b0;
         end else begin
            rsp_c_d    = '0;
            rsp_zero_d = 1'b0;
            rsp_err_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_c_q    <= '0;
         rsp_zero_q <= 1'b0;
         rsp_id_q   <= 1'b0;
         rsp_err_q  <= 1'b0;
      end else begin
         rsp_c_q    <= rsp_c_d;
         rsp_zero_q <= rsp_zero_d;
         rsp_id_q   <= rsp_id_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign rsp_c    = rsp_c_q;
   assign rsp_zero = rsp_zero_q;
   assign rsp_id   = rsp_id_q;
   assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb with a behavioural ALU and arbitration model.
module tb_alu_share_arb;
   localparam int W = 32;

   typedef struct {
      logic [31:0] c;
      logic        zero;
      logic        err;
      logic        id;
   } rsp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0, req1_valid = 1'b0;
   logic          req0_ready, req1_ready;
   logic [3:0]    req0_op = 4'd0, req1_op = 4'd0;
   logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [W-1:0]  alu_a, alu_b, alu_c;
   logic [3:0]    alu_ctrl;
   logic          alu_zero;
   logic          rsp_valid, rsp_id, rsp_zero, rsp_err;
   logic          rsp_ready = 1'b1;
   logic [W-1:0]  rsp_c;

   int            n_chk = 0, n_fail = 0;
   rsp_t          sb_q[$];
   rsp_t          log_q[$];
   rsp_t          alu_r, exp_r, act_r;
   logic          pref = 1'b0, hs0 = 1'b0, hs1 = 1'b0;
   logic          hold_prev = 1'b0;
   rsp_t          prev_r;
   logic          m_full, m_can, m_any, m_win;
   logic [3:0]    legal_ops [12] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                     4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};

   alu_share_arb #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .alu_c(alu_c), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_c(rsp_c), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // What the ALU computes for a code; shifts move B by A[4:0].
   function automatic rsp_t model(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic id);
      rsp_t r;
      logic signed [31:0] sb;
      sb = b;
      r.c = '0; r.zero = 1'b0; r.err = 1'b0; r.id = id;
      case (op)
         4'd0:  r.c = a & b;
         4'd1:  r.c = a | b;
         4'd2:  r.c = a + b;
         4'd3:  r.c = a ^ b;
         4'd4:  r.c = b << a[4:0];
         4'd5:  r.c = b >> a[4:0];
         4'd6:  r.c = a - b;
         4'd7:  r.c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd8:  r.c = sb >>> a[4:0];
         4'd9:  begin r.zero = (a == b); r.c = {31'd0, r.zero}; end
         4'd10: begin r.zero = (a != b); r.c = {31'd0, r.zero}; end
         4'd12: r.c = ~(a | b);
         default: r.err = 1'b1;
      endcase
      return r;
   endfunction

   // Shared ALU stand-in; unknown codes leave junk the arbiter must not pass on.
   always_comb begin
      alu_r = model(alu_ctrl, alu_a, alu_b, 1'b0);
      alu_c = alu_r.err ? 32'hDEADBEEF : alu_r.c;
      alu_zero = alu_r.err ? 1'b1 : alu_r.zero;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
         pref = 1'b0; hs0 = 1'b0; hs1 = 1'b0; hold_prev = 1'b0;
      end else begin
         m_full = (sb_q.size() != 0);
         chk("rsp_valid", rsp_valid, m_full);
         if (hold_prev) begin
            chk("hold_c", rsp_c, prev_r.c);
            chk("hold_zero", rsp_zero, prev_r.zero);
            chk("hold_id", rsp_id, prev_r.id);
            chk("hold_err", rsp_err, prev_r.err);
         end
         m_can = !m_full | rsp_ready;
         m_any = req0_valid | req1_valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
         m_win = !req0_valid;
`else
         m_win = (req0_valid & req1_valid) ? pref : req1_valid;
`endif
         chk("req0_ready", req0_ready, m_can & m_any & !m_win);
         chk("req1_ready", req1_ready, m_can & m_any & m_win);
         chk("alu_a", alu_a, !m_any ? 32'd0 : (m_win ? req1_a : req0_a));
         chk("alu_b", alu_b, !m_any ? 32'd0 : (m_win ? req1_b : req0_b));
         chk("alu_ctrl", alu_ctrl, !m_any ? 4'd0 : (m_win ? req1_op : req0_op));
         if (rsp_valid && rsp_ready && m_full) begin
            exp_r = sb_q.pop_front();
            chk("rsp_c", rsp_c, exp_r.c);
            chk("rsp_zero", rsp_zero, exp_r.zero);
            chk("rsp_id", rsp_id, exp_r.id);
            chk("rsp_err", rsp_err, exp_r.err);
            act_r.c = rsp_c; act_r.zero = rsp_zero; act_r.err = rsp_err; act_r.id = rsp_id;
            log_q.push_back(act_r);
         end
         hs0 = req0_valid & req0_ready;
         hs1 = req1_valid & req1_ready;
         if (hs0) sb_q.push_back(model(req0_op, req0_a, req0_b, 1'b0));
         if (hs1) sb_q.push_back(model(req1_op, req1_a, req1_b, 1'b1));
         if (hs0 | hs1) pref = ~pref;
         hold_prev = rsp_valid & !rsp_ready;
         prev_r.c = rsp_c; prev_r.zero = rsp_zero; prev_r.id = rsp_id; prev_r.err = rsp_err;
      end
   end

   task automatic drive(input int n, input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      if (n == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   task automatic wait_acc(input int n, input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(posedge clk); #1;
         done = (n == 0) ? hs0 : hs1;
      end
      if (!done) chk(name, 32'd0, 32'd1);
   endtask

   task automatic rand_req(input int n);
      logic [3:0]  op;
      logic [31:0] a, b;
      op = ($urandom_range(0, 9) == 0) ? 4'hF - 4'($urandom_range(0, 2)) * 4'd2
                                       : legal_ops[$urandom_range(0, 11)];
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      drive(n, $urandom_range(0, 9) < 6, op, a, b);
   endtask

   initial begin
      drive(0, 1'b1, 4'd2, 32'd5, 32'd7);
      repeat (2) @(posedge clk);
      #2;
      chk("reset_ready0", req0_ready, 1'b0);
      chk("reset_valid", rsp_valid, 1'b0);
      chk("reset_c", rsp_c, 32'd0);
      drive(0, 1'b0, 4'd0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Contention: both requesters present for eight cycles.
      log_q.delete();
      drive(0, 1'b1, 4'd6, 32'd9, 32'd4);
      drive(1, 1'b1, 4'd7, 32'hFFFF_FFFF, 32'd2);
      repeat (8) @(posedge clk);
      #1;
      drive(0, 1'b0, 4'd0, 0, 0);
      drive(1, 1'b0, 4'd0, 0, 0);
      @(posedge clk); #1;
      chk("contention_count", log_q.size() >= 4, 1'b1);
      if (log_q.size() >= 4) begin
         for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            chk("contention_id", log_q[i].id, 1'b0);
            chk("contention_c", log_q[i].c, 32'd5);
`else
            chk("contention_id", log_q[i].id, i % 2);
            chk("contention_c", log_q[i].c, (i % 2) ? 32'd1 : 32'd5);
`endif
         end
      end

      // Backpressure on a beq result, with an sra waiting behind it.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      drive(1, 1'b1, 4'd9, 32'd3, 32'd3);
      wait_acc(1, "bp_accept_timeout");
      drive(1, 1'b0, 4'd0, 0, 0);
      drive(0, 1'b1, 4'd8, 32'd4, 32'h8000_0000);
      repeat (3) begin
         @(posedge clk); #2;
         chk("bp_zero", rsp_zero, 1'b1);
         chk("bp_c", rsp_c, 32'd1);
         chk("bp_ready0", req0_ready, 1'b0);
         chk("bp_ready1", req1_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("pass_ready0", req0_ready, 1'b1);
      wait_acc(0, "pass_accept_timeout");
      drive(0, 1'b0, 4'd0, 0, 0);
      #1;
      chk("pass_c", rsp_c, 32'hF800_0000);

      // Illegal op, then a legal one clears the error.
      drive(1, 1'b1, 4'hF, 32'd6, 32'd6);
      wait_acc(1, "illegal_timeout");
      drive(1, 1'b0, 4'd0, 0, 0);
      #1;
      chk("illegal_err", rsp_err, 1'b1);
      chk("illegal_c", rsp_c, 32'd0);
      chk("illegal_zero", rsp_zero, 1'b0);
      chk("illegal_id", rsp_id, 1'b1);
      drive(1, 1'b1, 4'd0, 32'h0000_F0F0, 32'h0000_FF00);
      wait_acc(1, "legal_timeout");
      drive(1, 1'b0, 4'd0, 0, 0);
      #1;
      chk("legal_err", rsp_err, 1'b0);
      chk("legal_c", rsp_c, 32'h0000_F000);

      // Random traffic; requesters hold an op until it is taken.
      repeat (400) begin
         @(posedge clk); #1;
         if (!req0_valid || hs0) rand_req(0);
         if (!req1_valid || hs1) rand_req(1);
         rsp_ready = ($urandom_range(0, 9) < 7);
      end

      // Mid-stream reset with a result held.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (!req0_valid) drive(0, 1'b1, 4'd2, 32'd1, 32'd1);
      for (int i = 0; i < 20 && !rsp_valid; i++) begin
         @(posedge clk); #1;
      end
      chk("prereset_full", rsp_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", rsp_valid, 1'b0);
      chk("arst_c", rsp_c, 32'd0);
      chk("arst_zero", rsp_zero, 1'b0);
      chk("arst_id", rsp_id, 1'b0);
      chk("arst_err", rsp_err, 1'b0);
      chk("arst_ready0", req0_ready, 1'b0);
      chk("arst_ready1", req1_ready, 1'b0);
      drive(0, 1'b0, 4'd0, 0, 0);
      drive(1, 1'b0, 4'd0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      drive(0, 1'b1, 4'd2, 32'd5, 32'd7);
      drive(1, 1'b1, 4'd0, 32'd3, 32'd5);
      wait_acc(0, "post_reset_timeout");
      drive(0, 1'b0, 4'd0, 0, 0);
      #1;
      chk("post_reset_c", rsp_c, 32'd12);
      chk("post_reset_id", rsp_id, 1'b0);
      wait_acc(1, "post_reset_r1_timeout");
      drive(1, 1'b0, 4'd0, 0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("drain", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
